// File: rtl/iter_alu_pkg.sv
// iter_alu_pkg: ALU op codes, branch compare codes and FSM state encoding
// shared by iter_alu and the ALU control unit.
package iter_alu_pkg;
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1010;
   localparam logic [3:0] ALU_SRL = 4'b1011;
   localparam logic [3:0] BR_EQ   = 4'b0000;
   localparam logic [3:0] BR_NE   = 4'b1010;
   localparam logic [3:0] BR_LT   = 4'b1000;
   localparam logic [3:0] BR_GE   = 4'b1011;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/iter_alu_shifter.sv
// iter_alu_shifter: 1-bit-per-cycle logical shifter; done marks the edge
// that performs the final shift, whose value is presented on next_val.
module iter_alu_shifter
   import iter_alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   load,
   input  logic                   right,
   input  logic [DATA_WIDTH-1:0]  din,
   input  logic [SHAMT_WIDTH-1:0] amount,
   output logic [DATA_WIDTH-1:0]  next_val,
   output logic                   done
);
   logic [DATA_WIDTH-1:0]  sh_q;
   logic [SHAMT_WIDTH-1:0] cnt;
   logic                   dir_q;
   assign next_val = dir_q ? sh_q >> 1 : sh_q << 1;
   assign done     = cnt == SHAMT_WIDTH'(1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_q  <= '0;
         cnt   <= '0;
         dir_q <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else if (load) begin
         sh_q  <= din;
         cnt   <= amount;
         dir_q <= right;
      end else if (cnt != '0) begin
         sh_q <= next_val;
         cnt  <= cnt - SHAMT_WIDTH'(1);
      end
   end
endmodule

// File: rtl/iter_alu.sv
// iter_alu: execute-stage ALU with valid/ready handshake; SLL/SRL iterate one
// bit per cycle unless ITER_ALU_FAST_SHIFT_EN selects a barrel shifter.
module iter_alu
   import iter_alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic                  in_is_branch,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_bcond,
   output logic                  out_illegal
);
   state_t                 state, nxt;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic [DATA_WIDTH-1:0]  alu_res, sh_val;
   logic                   alu_bcond, alu_ill, start_shift, sh_done, accept;
   assign shamt     = in_b[SHAMT_WIDTH-1:0];
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_ready && in_valid;
`ifdef ITER_ALU_FAST_SHIFT_EN
   assign start_shift = 1'b0;
   assign sh_done     = 1'b0;
   assign sh_val      = '0;
`else
   // zero-amount shifts skip SHIFT: the combinational path already yields in_a
   assign start_shift = !in_is_branch && (in_op == ALU_SLL || in_op == ALU_SRL) && shamt != '0;
   iter_alu_shifter #(.DATA_WIDTH(DATA_WIDTH), .SHAMT_WIDTH(SHAMT_WIDTH)) u_shifter (
      .clk(clk), .reset(reset), .flush(flush), .load(accept && start_shift),
      .right(in_op == ALU_SRL), .din(in_a), .amount(shamt),
      .next_val(sh_val), .done(sh_done)
   );
`endif
   always_comb begin
      alu_res   = '0;
      alu_bcond = 1'b0;
      alu_ill   = 1'b0;
      if (in_is_branch) begin
         alu_res = in_a - in_b;
         case (in_op)
            BR_EQ:   alu_bcond = in_a == in_b;
            BR_NE:   alu_bcond = in_a != in_b;
            BR_LT:   alu_bcond = $signed(in_a) < $signed(in_b);
            BR_GE:   alu_bcond = $signed(in_a) >= $signed(in_b);
            default: begin
               alu_res = '0;
               alu_ill = 1'b1;
            end
         endcase
      end else begin
         case (in_op)
            ALU_ADD: alu_res = in_a + in_b;
            ALU_SUB: alu_res = in_a - in_b;
            ALU_AND: alu_res = in_a & in_b;
            ALU_OR:  alu_res = in_a | in_b;
            ALU_XOR: alu_res = in_a ^ in_b;
`ifdef ITER_ALU_FAST_SHIFT_EN
            ALU_SLL: alu_res = in_a << shamt;
            ALU_SRL: alu_res = in_a >> shamt;
`else
            ALU_SLL, ALU_SRL: alu_res = in_a;
`endif
            default: alu_ill = 1'b1;
         endcase
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (in_valid) nxt = start_shift ? SHIFT : DONE;
         SHIFT:   if (sh_done) nxt = DONE;
         DONE:    if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (flush) nxt = IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         out_result  <= '0;
         out_bcond   <= 1'b0;
         out_illegal <= 1'b0;
      end else begin
         state <= nxt;
         if (flush) begin
            out_result  <= '0;
            out_bcond   <= 1'b0;
            out_illegal <= 1'b0;
         end else if (accept) begin
            out_result  <= alu_res;
            out_bcond   <= alu_bcond;
            out_illegal <= alu_ill;
         end else if (state == SHIFT && sh_done) begin
            out_result <= sh_val;
         end
      end
   end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed self-checking bench for iter_alu (default iterative
// build; expected shift latencies follow ITER_ALU_FAST_SHIFT_EN if defined).
module tb_iter_alu;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = 4'b0000;
   logic        in_is_branch = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_bcond;
   logic        out_illegal;
   int          errors = 0;
   int          checks = 0;

   iter_alu dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_is_branch(in_is_branch), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_bcond(out_bcond), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // offers one op, returns edges from accept (inclusive) until out_valid
   task automatic issue(input logic [3:0] op, input logic br, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
      in_op = op; in_is_branch = br; in_a = a; in_b = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", out_result); end
      checks++; if (out_bcond !== 1'b0) begin errors++; $display("FAIL reset_bcond: got %b want 0", out_bcond); end
      checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_add();
      int lat;
      issue(4'b0000, 1'b0, 32'h7FFF_FFFF, 32'h1, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
      checks++; if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got %h want 80000000", out_result); end
      checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal: got %b want 0", out_illegal); end
      checks++; if (out_bcond !== 1'b0) begin errors++; $display("FAIL add_bcond: got %b want 0", out_bcond); end
      in_a = 32'h1234_5678; in_b = 32'h1111_1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_result !== 32'h8000_0000) begin errors++; $display("FAIL add_hold[%0d]: valid=%b result=%h want 1/80000000", i, out_valid, out_result); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_hold_in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      consume();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL add_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_shift();
      int lat;
      int exp6, exp32, exp5;
`ifdef ITER_ALU_FAST_SHIFT_EN
      exp6 = 1; exp32 = 1; exp5 = 1;
`else
      exp6 = 6; exp32 = 32; exp5 = 5;
`endif
      issue(4'b1010, 1'b0, 32'h0000_0001, 32'd5, lat);
      checks++; if (lat !== exp6) begin errors++; $display("FAIL sll5_latency: got %0d want %0d", lat, exp6); end
      checks++; if (out_result !== 32'h0000_0020) begin errors++; $display("FAIL sll5_result: got %h want 00000020", out_result); end
      consume();
      issue(4'b1011, 1'b0, 32'h8000_0000, 32'd31, lat);
      checks++; if (lat !== exp32) begin errors++; $display("FAIL srl31_latency: got %0d want %0d", lat, exp32); end
      checks++; if (out_result !== 32'h0000_0001) begin errors++; $display("FAIL srl31_result: got %h want 00000001", out_result); end
      consume();
      issue(4'b1011, 1'b0, 32'hF000_00F0, 32'hFFFF_FFE4, lat);
      checks++; if (lat !== exp5) begin errors++; $display("FAIL srl4_latency: got %0d want %0d", lat, exp5); end
      checks++; if (out_result !== 32'h0F00_000F) begin errors++; $display("FAIL srl4_result: got %h want 0F00000F", out_result); end
      consume();
      issue(4'b1010, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL sll0_latency: got %0d want 1", lat); end
      checks++; if (out_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sll0_result: got %h want DEADBEEF", out_result); end
      consume();
   endtask

   task automatic test_logic();
      int lat;
      issue(4'b0100, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat);
      checks++; if (out_result !== 32'h00F0_000F) begin errors++; $display("FAIL and_result: got %h want 00F0000F", out_result); end
      consume();
      issue(4'b0101, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat);
      checks++; if (out_result !== 32'hFFF0_0FFF) begin errors++; $display("FAIL or_result: got %h want FFF00FFF", out_result); end
      consume();
      issue(4'b1000, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat);
      checks++; if (out_result !== 32'hFF00_0FF0) begin errors++; $display("FAIL xor_result: got %h want FF000FF0", out_result); end
      consume();
   endtask

   task automatic test_branch();
      int lat;
      issue(4'b1000, 1'b1, 32'hFFFF_FFFF, 32'h1, lat);
      checks++; if (out_bcond !== 1'b1) begin errors++; $display("FAIL br_lt_bcond: got %b want 1", out_bcond); end
      checks++; if (out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL br_lt_result: got %h want FFFFFFFE", out_result); end
      consume();
      issue(4'b1011, 1'b1, 32'hFFFF_FFFF, 32'h1, lat);
      checks++; if (lat !== 1 || out_bcond !== 1'b0) begin errors++; $display("FAIL br_ge_bcond: lat=%0d bcond=%b want 1/0", lat, out_bcond); end
      consume();
      issue(4'b1010, 1'b1, 32'd5, 32'd5, lat);
      checks++; if (out_bcond !== 1'b0 || out_result !== 32'h0) begin errors++; $display("FAIL br_ne_bcond: bcond=%b result=%h want 0/0", out_bcond, out_result); end
      consume();
      issue(4'b0000, 1'b1, 32'd5, 32'd5, lat);
      checks++; if (out_bcond !== 1'b1 || out_illegal !== 1'b0) begin errors++; $display("FAIL br_eq_bcond: bcond=%b illegal=%b want 1/0", out_bcond, out_illegal); end
      consume();
   endtask

   task automatic test_illegal();
      int lat;
      issue(4'b0011, 1'b0, 32'h1234_5678, 32'h1, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL ill_latency: got %0d want 1", lat); end
      checks++; if (out_result !== 32'h0 || out_illegal !== 1'b1) begin errors++; $display("FAIL ill_alu: result=%h illegal=%b want 0/1", out_result, out_illegal); end
      consume();
      issue(4'b0001, 1'b1, 32'd9, 32'd3, lat);
      checks++; if (out_result !== 32'h0 || out_illegal !== 1'b1 || out_bcond !== 1'b0) begin errors++; $display("FAIL ill_branch: result=%h illegal=%b bcond=%b want 0/1/0", out_result, out_illegal, out_bcond); end
      consume();
   endtask

   task automatic test_flush();
      int  lat;
      logic seen = 1'b0;
      in_op = 4'b1010; in_is_branch = 1'b0; in_a = 32'h1; in_b = 32'd10; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: out_valid rose=%b want 0", seen); end
      issue(4'b0000, 1'b0, 32'd2, 32'd3, lat);
      checks++; if (lat !== 1 || out_result !== 32'd5) begin errors++; $display("FAIL flush_next_add: lat=%0d result=%h want 1/00000005", lat, out_result); end
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin errors++; $display("FAIL flush_done: valid=%b ready=%b result=%h want 0/1/0", out_valid, in_ready, out_result); end
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      in_op = 4'b1010; in_is_branch = 1'b0; in_a = 32'h3; in_b = 32'd20; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin errors++; $display("FAIL async_reset: valid=%b ready=%b result=%h want 0/1/0", out_valid, in_ready, out_result); end
      tick();
      #2;
      reset = 1'b1;
      tick();
      issue(4'b0001, 1'b0, 32'd3, 32'd5, lat);
      checks++; if (lat !== 1 || out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_after_reset: lat=%0d result=%h want 1/FFFFFFFE", lat, out_result); end
      consume();
   endtask

   initial begin
      test_reset();
      test_add();
      test_shift();
      test_logic();
      test_branch();
      test_illegal();
      test_flush();
      test_reset_mid_shift();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control unit, plus two 32-bit operands from the register file / immediate mux.
- Arithmetic and logic ops complete in one cycle.
- SLL/SRL run on an iterative 1-bit-per-cycle shifter, which saves area.
- Valid/ready handshake on input and output so the multicycle control FSM can stall on it.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from in_b[SHAMT_WIDTH-1:0].

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept; high only in IDLE
- in_op  input  4  ALU op code (0000 ADD, 0001 SUB, 0100 AND, 0101 OR, 1000 XOR, 1010 SLL, 1011 SRL)
- in_is_branch  input  1  reinterpret in_op as branch compare (0000 EQ, 1010 NE, 1000 LT signed, 1011 GE signed)
- in_a  input  DATA_WIDTH  operand A
- in_b  input  DATA_WIDTH  operand B
- out_valid  output  1  result held valid
- out_ready  input  1  consumer takes result
- out_result  output  DATA_WIDTH  result
- out_bcond  output  1  branch outcome; 0 when not a branch
- out_illegal  output  1  unsupported code seen

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_bcond=0, out_illegal=0, shift counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Accept on in_valid && in_ready; operands and code are latched at that edge.
  - Non-shift or branch op: result computed combinationally and registered; next state DONE (latency 1).
  - SLL/SRL with shamt=0: result = in_a; next state DONE (latency 1).
  - SLL/SRL with shamt=n>0: load shift register with in_a and counter with n; next state SHIFT.
- SHIFT:
  - Each cycle shifts one bit (SLL left, SRL logical right, zero fill) and decrements the counter.
  - When the counter reaches 1, that edge performs the last shift and moves to DONE.
  - Total latency 1+n edges from accept to out_valid (shamt=31 gives 32).
- DONE:
  - out_valid=1; out_result, out_bcond and out_illegal are held stable until out_ready.
  - On out_valid && out_ready: IDLE at the next edge. in_ready rises one cycle after the handshake; there is no same-cycle bypass.
- Arithmetic: ADD/SUB are modulo 2^DATA_WIDTH with no overflow flag.
- Branch: out_result = a-b. out_bcond:
  - EQ: a==b
  - NE: a!=b
  - LT: $signed(a)<$signed(b)
  - GE: $signed(a)>=$signed(b)
- Unsupported codes (non-branch codes outside the list; branch codes outside EQ/NE/LT/GE): out_result=0, out_bcond=0, out_illegal=1, latency 1.
- flush=1:
  - In any state, next state is IDLE and out_valid=0; the latched result is discarded.
  - flush has priority over accept and over the output handshake in the same cycle.
- in_valid while not IDLE is ignored; the producer must hold it.
- Reset asserted mid-SHIFT aborts immediately with all outputs at reset values.

Optional Feature:
- ITER_ALU_FAST_SHIFT_EN
  - Defined: SLL/SRL use a single-cycle barrel shifter; every op has latency 1 and the SHIFT state is never entered.
  - Undefined: iterative shifter as specified above.
- Handshake and flush rules are identical in both builds.

Decomposition:
- Shared package: ALU op code localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL), branch compare codes (BR_EQ, BR_NE, BR_LT, BR_GE), and the state encoding. The ALU control unit must use the same package.
- One sub-module, iter_alu_shifter: shift register, counter and done pulse. Top level keeps the FSM, combinational ops and branch compare.

Test Plan:
- ADD: a=0x7FFFFFFF, b=1, in_is_branch=0 -> out_valid one edge after accept, out_result=0x80000000, out_illegal=0; out_ready held 0 for 3 cycles -> result stable, in_ready=0.
- SLL: a=0x00000001, b=5 -> out_valid exactly 6 edges after accept, out_result=0x00000020. SRL: a=0x80000000, b=31 -> 32 edges, result 0x00000001 (with ITER_ALU_FAST_SHIFT_EN: 1 edge for both).
- Branch LT: a=0xFFFFFFFF, b=1 -> out_bcond=1. Branch GE with the same operands -> out_bcond=0. NE: a=b=5 -> out_bcond=0.
- Illegal: in_op=0011, in_is_branch=0 -> out_result=0, out_illegal=1, latency 1.
- flush asserted on the 3rd SHIFT cycle of a b=10 shift -> IDLE next edge, out_valid never rises, in_ready=1; the next ADD completes normally.
- reset driven low mid-SHIFT, asynchronously between clock edges -> out_valid=0, in_ready=1 immediately. After release, SUB a=3, b=5 -> out_result=0xFFFFFFFE.
